// File: rtl/rv32i_membus_pkg.sv
// Shared RV32I constants: opcodes, CSR addresses and memory-bus arbiter definitions.
package rv32i_membus_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrCycle   = 12'hC00;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIWait = 2'd1,
    StDWait = 2'd2,
    StDone  = 2'd3
  } membus_state_e;

  localparam logic [31:0] MembusErrData = 32'hFFFF_FFFF;

endpackage

// File: rtl/rv32i_membus_timer.sv
// Bus wait counter: cleared while idle, counts WAIT cycles without ack, flags the abort cycle.
module membus_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires during the WAIT cycle whose increment would reach TIMEOUT.
  assign expired_o = enable_i && (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/rv32i_membus.sv
// Arbitrates the CPU instruction and data ports onto one shared memory bus.
module rv32i_membus
  import rv32i_membus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = MembusErrData
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_i_addr,
  input  logic        mem_i_rstrb,
  output logic [31:0] mem_i_rdata,
  output logic        mem_i_rbusy,
  input  logic [31:0] mem_d_addr,
  input  logic [31:0] mem_d_wdata,
  input  logic [3:0]  mem_d_wmask,
  input  logic        mem_d_wstrb,
  input  logic        mem_d_rstrb,
  output logic [31:0] mem_d_rdata,
  output logic        mem_d_rbusy,
  output logic        mem_d_wbusy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  membus_state_e state_q, state_d;
  logic          owner_d_q, owner_d_d;  // 1: data port owns the transaction
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          done_i_q, done_i_d;
  logic          done_d_q, done_d_d;
  logic          err_q, err_d;

  logic d_strb;
  logic in_wait;
  logic tmr_expired;

  assign d_strb  = mem_d_rstrb | mem_d_wstrb;
  assign in_wait = (state_q == StIWait) || (state_q == StDWait);

  membus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == StIdle),
    .enable_i  (in_wait && !bus_ack),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    done_i_d  = done_i_q;
    done_d_d  = done_d_q;
    err_d     = err_q;

    if (!mem_i_rstrb) done_i_d = 1'b0;
    if (!d_strb)      done_d_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_strb && !done_d_q) begin
          state_d   = StDWait;
          owner_d_d = 1'b1;
          req_d     = 1'b1;
          we_d      = mem_d_wstrb;
          addr_d    = mem_d_addr;
          wdata_d   = mem_d_wdata;
          wmask_d   = mem_d_wstrb ? mem_d_wmask : 4'b1111;
        end else if (mem_i_rstrb && !done_i_q) begin
          state_d   = StIWait;
          owner_d_d = 1'b0;
          req_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = mem_i_addr;
          wdata_d   = '0;
          wmask_d   = 4'b1111;
        end
      end
      StIWait, StDWait: begin
        if (bus_ack || tmr_expired) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!bus_ack) err_d = 1'b1;
          // Aborted writes are simply dropped; aborted reads return ERR_DATA.
          if (!we_q) begin
            if (owner_d_q) begin
              d_rdata_d = bus_ack ? bus_rdata : ERR_DATA;
            end else begin
              i_rdata_d = bus_ack ? bus_rdata : ERR_DATA;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (owner_d_q) begin
          done_d_d = 1'b1;
        end else begin
          done_i_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_d_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      done_i_q  <= 1'b0;
      done_d_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      done_i_q  <= done_i_d;
      done_d_q  <= done_d_d;
      err_q     <= err_d;
    end
  end

  assign mem_i_rbusy = mem_i_rstrb & ~done_i_q;
  assign mem_d_rbusy = mem_d_rstrb & ~done_d_q;
  assign mem_d_wbusy = mem_d_wstrb & ~done_d_q;
  assign mem_i_rdata = i_rdata_q;
  assign mem_d_rdata = d_rdata_q;
  assign bus_req     = req_q;
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_wmask   = wmask_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_rv32i_membus.sv
// Directed bench for rv32i_membus; the bench itself plays the memory and drives bus_ack.
module tb_rv32i_membus;

  logic        clk;
  logic        rst;
  logic [31:0] mem_i_addr;
  logic        mem_i_rstrb;
  logic [31:0] mem_i_rdata;
  logic        mem_i_rbusy;
  logic [31:0] mem_d_addr;
  logic [31:0] mem_d_wdata;
  logic [3:0]  mem_d_wmask;
  logic        mem_d_wstrb;
  logic        mem_d_rstrb;
  logic [31:0] mem_d_rdata;
  logic        mem_d_rbusy;
  logic        mem_d_wbusy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int n_cmp;
  int n_err;

  rv32i_membus #(
    .TIMEOUT  (4),
    .ERR_DATA (32'hFFFF_FFFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_i_addr  (mem_i_addr),
    .mem_i_rstrb (mem_i_rstrb),
    .mem_i_rdata (mem_i_rdata),
    .mem_i_rbusy (mem_i_rbusy),
    .mem_d_addr  (mem_d_addr),
    .mem_d_wdata (mem_d_wdata),
    .mem_d_wmask (mem_d_wmask),
    .mem_d_wstrb (mem_d_wstrb),
    .mem_d_rstrb (mem_d_rstrb),
    .mem_d_rdata (mem_d_rdata),
    .mem_d_rbusy (mem_d_rbusy),
    .mem_d_wbusy (mem_d_wbusy),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wmask   (bus_wmask),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    mem_i_addr  = '0;
    mem_i_rstrb = 1'b0;
    mem_d_addr  = '0;
    mem_d_wdata = '0;
    mem_d_wmask = '0;
    mem_d_wstrb = 1'b0;
    mem_d_rstrb = 1'b0;
    bus_ack     = 1'b0;
    bus_rdata   = '0;

    // Reset values and busy-follows-strobe while in reset
    #12;
    check("rst_req",    32'(bus_req),   32'd0);
    check("rst_we",     32'(bus_we),    32'd0);
    check("rst_addr",   bus_addr,       32'd0);
    check("rst_wdata",  bus_wdata,      32'd0);
    check("rst_wmask",  32'(bus_wmask), 32'd0);
    check("rst_irdata", mem_i_rdata,    32'd0);
    check("rst_drdata", mem_d_rdata,    32'd0);
    check("rst_err",    32'(bus_err),   32'd0);
    mem_i_rstrb = 1'b1;
    mem_d_wstrb = 1'b1;
    #1;
    check("rst_irbusy", 32'(mem_i_rbusy), 32'd1);
    check("rst_dwbusy", 32'(mem_d_wbusy), 32'd1);
    check("rst_drbusy", 32'(mem_d_rbusy), 32'd0);
    mem_i_rstrb = 1'b0;
    mem_d_wstrb = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Instruction fetch, ack in the second bus_req cycle
    mem_i_addr  = 32'h0000_0100;
    mem_i_rstrb = 1'b1;
    #1;
    check("if_busy_n", 32'(mem_i_rbusy), 32'd1);
    step();
    check("if_req",    32'(bus_req),     32'd1);
    check("if_addr",   bus_addr,         32'h0000_0100);
    check("if_we",     32'(bus_we),      32'd0);
    check("if_busy1",  32'(mem_i_rbusy), 32'd1);
    step();
    check("if_req_held", 32'(bus_req),   32'd1);
    check("if_busy2",  32'(mem_i_rbusy), 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h0000_0013;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check("if_done_req", 32'(bus_req),   32'd0);
    check("if_rdata",  mem_i_rdata,      32'h0000_0013);
    check("if_busy3",  32'(mem_i_rbusy), 32'd1);
    step();
    check("if_busy4",  32'(mem_i_rbusy), 32'd0);
    step();
    check("if_busy5",  32'(mem_i_rbusy), 32'd0);
    check("if_norereq", 32'(bus_req),    32'd0);
    mem_i_rstrb = 1'b0;
    step();

    // Store word, ack in the first bus_req cycle
    mem_d_addr  = 32'h0000_0204;
    mem_d_wdata = 32'hDEAD_BEEF;
    mem_d_wmask = 4'b1111;
    mem_d_wstrb = 1'b1;
    #1;
    check("sw_busy_n", 32'(mem_d_wbusy), 32'd1);
    step();
    check("sw_req",   32'(bus_req),   32'd1);
    check("sw_we",    32'(bus_we),    32'd1);
    check("sw_addr",  bus_addr,       32'h0000_0204);
    check("sw_wdata", bus_wdata,      32'hDEAD_BEEF);
    check("sw_wmask", 32'(bus_wmask), 32'hF);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("sw_busy2", 32'(mem_d_wbusy), 32'd1);
    step();
    check("sw_busy3", 32'(mem_d_wbusy), 32'd0);
    check("sw_rdata", mem_d_rdata,      32'd0);
    mem_d_wstrb = 1'b0;
    step();

    // Data read with wmask 0: bus mask forced to all lanes
    mem_d_addr  = 32'h0000_0300;
    mem_d_wmask = 4'b0000;
    mem_d_rstrb = 1'b1;
    step();
    check("ld_we",    32'(bus_we),    32'd0);
    check("ld_wmask", 32'(bus_wmask), 32'hF);
    check("ld_addr",  bus_addr,       32'h0000_0300);
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check("ld_rdata", mem_d_rdata, 32'hCAFE_F00D);
    step();
    check("ld_busy3", 32'(mem_d_rbusy), 32'd0);
    mem_d_rstrb = 1'b0;
    step();

    // Both data strobes: treated as a write, read data untouched
    mem_d_addr  = 32'h0000_0208;
    mem_d_wdata = 32'h1234_5678;
    mem_d_wmask = 4'b0011;
    mem_d_rstrb = 1'b1;
    mem_d_wstrb = 1'b1;
    step();
    check("rw_we",    32'(bus_we),    32'd1);
    check("rw_wmask", 32'(bus_wmask), 32'h3);
    check("rw_wdata", bus_wdata,      32'h1234_5678);
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    step();
    check("rw_rdata", mem_d_rdata,      32'hCAFE_F00D);
    check("rw_wbusy", 32'(mem_d_wbusy), 32'd0);
    check("rw_rbusy", 32'(mem_d_rbusy), 32'd0);
    mem_d_rstrb = 1'b0;
    mem_d_wstrb = 1'b0;
    step();

    // Ack while idle is ignored
    bus_ack   = 1'b1;
    bus_rdata = 32'hBADB_AD00;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    step();
    check("idle_ack_req",   32'(bus_req), 32'd0);
    check("idle_ack_drd",   mem_d_rdata,  32'hCAFE_F00D);
    check("idle_ack_ird",   mem_i_rdata,  32'h0000_0013);

    // Simultaneous requests: data first, then instruction
    mem_i_addr  = 32'h0000_0400;
    mem_i_rstrb = 1'b1;
    mem_d_addr  = 32'h0000_0500;
    mem_d_rstrb = 1'b1;
    step();
    check("arb_first", bus_addr, 32'h0000_0500);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1111_1111;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check("arb_ibusy_done", 32'(mem_i_rbusy), 32'd1);
    step();
    check("arb_dbusy", 32'(mem_d_rbusy), 32'd0);
    check("arb_ibusy", 32'(mem_i_rbusy), 32'd1);
    step();
    check("arb_second_req",  32'(bus_req), 32'd1);
    check("arb_second_addr", bus_addr,     32'h0000_0400);
    bus_ack   = 1'b1;
    bus_rdata = 32'h2222_2222;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    step();
    check("arb_ibusy_end", 32'(mem_i_rbusy), 32'd0);
    check("arb_irdata",    mem_i_rdata,      32'h2222_2222);
    check("arb_drdata",    mem_d_rdata,      32'h1111_1111);
    mem_i_rstrb = 1'b0;
    mem_d_rstrb = 1'b0;
    step();

    // Timeout with TIMEOUT=4: four WAIT cycles, then abort
    mem_d_addr  = 32'h0000_0600;
    mem_d_rstrb = 1'b1;
    step();
    step();
    step();
    step();
    check("to_req_w4", 32'(bus_req), 32'd1);
    check("to_err_w4", 32'(bus_err), 32'd0);
    step();
    check("to_req_done", 32'(bus_req),     32'd0);
    check("to_err",      32'(bus_err),     32'd1);
    check("to_rdata",    mem_d_rdata,      32'hFFFF_FFFF);
    check("to_busy_d",   32'(mem_d_rbusy), 32'd1);
    step();
    check("to_busy_end", 32'(mem_d_rbusy), 32'd0);
    mem_d_rstrb = 1'b0;
    step();
    step();
    check("to_err_sticky", 32'(bus_err), 32'd1);

    // Async reset during D_WAIT, stale ack after release, re-issue
    mem_d_addr  = 32'h0000_0700;
    mem_d_rstrb = 1'b1;
    step();
    check("ar_req_pre", 32'(bus_req), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_req_async", 32'(bus_req),     32'd0);
    check("ar_err_clr",   32'(bus_err),     32'd0);
    check("ar_drdata",    mem_d_rdata,      32'd0);
    check("ar_busy_rst",  32'(mem_d_rbusy), 32'd1);
    step();
    rst       = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hBAD0_BAD0;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check("ar_reissue_req",  32'(bus_req), 32'd1);
    check("ar_reissue_addr", bus_addr,     32'h0000_0700);
    check("ar_stale_rdata",  mem_d_rdata,  32'd0);
    step();
    check("ar_busy_wait", 32'(mem_d_rbusy), 32'd1);
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_7777;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check("ar_rdata", mem_d_rdata, 32'h7777_7777);
    step();
    check("ar_busy_end", 32'(mem_d_rbusy), 32'd0);
    check("ar_err_end",  32'(bus_err),     32'd0);
    mem_d_rstrb = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
